// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } ctrl_state_t;

  localparam int TICK_DIV_DEFAULT = 100_000_000;

  // Bit positions of the buttons in the packed press vector
  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_RESET = 2;
  localparam int NUM_BTNS  = 3;

endpackage

// File: rtl/stopwatch_if.sv
// Button inputs and counter-control outputs of the stopwatch control stage.
interface stopwatch_if;
  logic start_btn;
  logic stop_btn;
  logic reset_btn;
  logic running;
  logic count_en;
  logic clear;

  modport master (output start_btn, stop_btn, reset_btn,
                  input  running, count_en, clear);
  modport slave  (input  start_btn, stop_btn, reset_btn,
                  output running, count_en, clear);
endinterface

// File: rtl/btn_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector for one button level.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // A held button yields one press; releases are ignored
  assign press = sync_q[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/idle control, one-per-second count strobe and counter clear pulse.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  sw
);

  localparam int             PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  LAST = PW'(TICK_DIV - 1);

  logic [NUM_BTNS-1:0] btn_vec;
  logic [NUM_BTNS-1:0] press;

  ctrl_state_t   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          clear_q, clear_d;

  assign btn_vec[BTN_START] = sw.start_btn;
  assign btn_vec[BTN_STOP]  = sw.stop_btn;
  assign btn_vec[BTN_RESET] = sw.reset_btn;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn [NUM_BTNS-1:0] (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_vec),
    .press (press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      clear_q <= clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clear_d = 1'b0;

    // Only the highest-priority press is acted on
    if (press[BTN_RESET]) begin
      state_d = IDLE;
      clear_d = 1'b1;
    end else if (press[BTN_STOP]) begin
      if (state_q == RUNNING) state_d = PAUSED;
    end else if (press[BTN_START]) begin
      if (state_q != RUNNING) state_d = RUNNING;
    end

    // Count on every RUNNING cycle, including the one that takes a stop,
    // so a tick cycle ending in a pause still wraps and holds at 0.
    if (state_d == IDLE)
      presc_d = '0;
    else if (state_q == RUNNING)
      presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
  end

  assign sw.running  = (state_q == RUNNING);
  assign sw.count_en = (state_q == RUNNING) && (presc_q == LAST);
  assign sw.clear    = clear_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed checks of stopwatch_ctrl with TICK_DIV=4, SYNC_STAGES=2.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  stopwatch_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %0b expected %0b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    edge_n++;
  endtask

  task automatic chk_all(input string tag, input logic r, input logic c, input logic cl);
    chk({tag, "_running"},  sw_if.running,  r);
    chk({tag, "_count_en"}, sw_if.count_en, c);
    chk({tag, "_clear"},    sw_if.clear,    cl);
  endtask

  initial begin
    sw_if.start_btn = 1'b0;
    sw_if.stop_btn  = 1'b0;
    sw_if.reset_btn = 1'b0;
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);

    // Start held from before edge 1: running after edge 3, ticks at 6, 10, 14
    rst = 1'b0;
    sw_if.start_btn = 1'b1;
    edge_n = 0;
    step(); chk("start_e1", sw_if.running, 1'b0);
    step(); chk("start_e2", sw_if.running, 1'b0);
    step(); chk_all("start_e3", 1'b1, 1'b0, 1'b0);
    for (int k = 4; k <= 14; k++) begin
      step();
      chk_all("start_run", 1'b1, (k % 4) == 2, 1'b0);
    end
    sw_if.start_btn = 1'b0;

    // Stop taken on edge 17 leaves the prescaler held at 2
    sw_if.stop_btn = 1'b1;
    step(); step();
    chk_all("pause_e16", 1'b1, 1'b0, 1'b0);
    step();
    chk_all("pause_e17", 1'b0, 1'b0, 1'b0);
    sw_if.stop_btn = 1'b0;
    for (int k = 18; k <= 37; k++) begin
      step();
      chk_all("paused", 1'b0, 1'b0, 1'b0);
    end

    // Resume: first tick one cycle after running rises
    sw_if.start_btn = 1'b1;
    step(); step();
    chk("resume_e39", sw_if.running, 1'b0);
    step(); chk_all("resume_e40", 1'b1, 1'b0, 1'b0);
    step(); chk_all("resume_e41", 1'b1, 1'b1, 1'b0);
    for (int k = 42; k <= 45; k++) begin
      step();
      chk_all("resume_run", 1'b1, (k % 4) == 1, 1'b0);
    end
    sw_if.start_btn = 1'b0;

    // Fresh start press held ~50 cycles while RUNNING: ignored, spacing stays 4
    for (int k = 46; k <= 95; k++) begin
      step();
      if (k == 47) sw_if.start_btn = 1'b1;
      if (k == 93) sw_if.start_btn = 1'b0;
      chk_all("held_start", 1'b1, (k % 4) == 1, 1'b0);
    end

    // All three pressed together, taken on edge 98 during a tick cycle
    sw_if.start_btn = 1'b1;
    sw_if.stop_btn  = 1'b1;
    sw_if.reset_btn = 1'b1;
    step(); chk_all("simul_e96", 1'b1, 1'b0, 1'b0);
    step(); chk_all("simul_e97", 1'b1, 1'b1, 1'b0);
    step(); chk_all("simul_e98", 1'b0, 1'b0, 1'b1);
    step(); chk_all("simul_e99", 1'b0, 1'b0, 1'b0);
    sw_if.start_btn = 1'b0;
    sw_if.stop_btn  = 1'b0;
    sw_if.reset_btn = 1'b0;
    step(); step();

    // Stop press in IDLE is ignored
    sw_if.stop_btn = 1'b1;
    for (int k = 102; k <= 107; k++) begin
      step();
      chk_all("idle_stop", 1'b0, 1'b0, 1'b0);
    end
    sw_if.stop_btn = 1'b0;

    // Start after the clear: prescaler restarted at 0, tick 3 cycles after rise
    sw_if.start_btn = 1'b1;
    step(); step();
    chk("restart_e109", sw_if.running, 1'b0);
    step(); chk_all("restart_e110", 1'b1, 1'b0, 1'b0);
    step(); chk("restart_e111", sw_if.count_en, 1'b0);
    step(); chk("restart_e112", sw_if.count_en, 1'b0);
    step(); chk_all("restart_e113", 1'b1, 1'b1, 1'b0);

    // Async rst mid-cycle with prescaler=3: outputs drop with no clock edge
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_all("rst_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    edge_n = 0;
    step(); chk("post_rst_e1", sw_if.running, 1'b0);
    step(); chk("post_rst_e2", sw_if.running, 1'b0);
    step(); chk_all("post_rst_e3", 1'b1, 1'b0, 1'b0);
    step(); chk("post_rst_e4", sw_if.count_en, 1'b0);
    step(); chk("post_rst_e5", sw_if.count_en, 1'b0);
    step(); chk_all("post_rst_e6", 1'b1, 1'b1, 1'b0);
    sw_if.start_btn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control stage directly upstream of the seconds counter. It converts three pre-debounced push-button levels (start, stop, reset) into a run/pause/idle state machine. It also generates the one-cycle-per-second `count_en` strobe that drives the seconds counter's enable input, and a one-cycle `clear` pulse that zeroes the seconds and minutes counters. It contains the only prescaler in the stopwatch datapath.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per counted second. Must be at least 2.
- `SYNC_STAGES`, default 2: flip-flop stages in each button synchroniser. Must be at least 2.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high. Clears all state.
- `start_btn`  in  1  start button level, debounced externally, asynchronous to `clk`.
- `stop_btn`  in  1  stop button level, debounced externally, asynchronous to `clk`.
- `reset_btn`  in  1  user-reset button level, debounced externally, asynchronous to `clk`.
- `running`  out  1  high while the state is RUNNING.
- `count_en`  out  1  one-cycle strobe, once per `TICK_DIV` cycles while RUNNING. Connects to the seconds counter `enable`.
- `clear`  out  1  one-cycle pulse that zeroes the downstream counters. It is ORed into their reset.

## Operation
- **Button path**
  - Each button passes through a `SYNC_STAGES` synchroniser, then a rising-edge detector.
  - The edge detector computes `press = sync_out & ~sync_prev`.
  - A held button produces exactly one press. Releases are ignored.
- **States:** IDLE, RUNNING, PAUSED.
- **Press priority** within one cycle: reset > stop > start. Only the highest-priority press present is acted on.
- **Transitions**
  - IDLE, start → RUNNING.
  - IDLE, stop → stay in IDLE (ignored).
  - RUNNING, stop → PAUSED.
  - RUNNING, start → stay in RUNNING (ignored).
  - PAUSED, start → RUNNING.
  - PAUSED, stop → stay in PAUSED (ignored).
  - Any state, reset → IDLE, and `clear` is pulsed. This includes reset while already in IDLE.
- **Prescaler**
  - Width is `$clog2(TICK_DIV)`, unsigned, counting 0 to `TICK_DIV-1`.
  - In RUNNING it increments every cycle and wraps from `TICK_DIV-1` to 0.
  - In PAUSED it holds its value, so the fractional second is preserved across a pause.
  - On any transition into IDLE it is forced to 0.
- **`count_en`**
  - Equals `(state == RUNNING) & (prescaler == TICK_DIV-1)`.
  - It is decoded combinationally from registers only, with no input-to-output path.
- **`clear`**
  - Registered.
  - High for exactly the one cycle that follows the clock edge on which a reset press is taken.
- **`rst` asserted**
  - State goes to IDLE, the prescaler goes to 0, and all synchroniser and edge registers go to 0, asynchronously.
  - A button still held when `rst` releases is seen as a fresh press once synchronised.

## Timing
- **Reset values:** `running`=0, `count_en`=0, `clear`=0.
- **Button to state change:** with a stable high button, the state changes on clock edge `SYNC_STAGES+1`, counted from the first edge that samples the button high. With the defaults this is edge 3.
- **First tick after start from IDLE**
  - `count_en` goes high `TICK_DIV-1` cycles after `running` rises.
  - It then repeats every `TICK_DIV` cycles.
  - The seconds counter increments on the edge that ends the `count_en` cycle.
- **Resume from PAUSED:** the first `count_en` comes `TICK_DIV-1-p` cycles after `running` rises, where `p` is the prescaler value held during the pause.
- **Stop on the tick cycle:** if a stop press is taken on the same edge that ends a `count_en` cycle, that tick still counts. The prescaler then holds at 0.
- **Reset on the tick cycle:** if a reset press is taken in a `count_en` cycle, `count_en` is high in that cycle and `clear` is high in the next cycle. Clear wins downstream.

## Structure
- **Package `stopwatch_pkg`:**
  - `ctrl_state_t` enum: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10.
  - Default `TICK_DIV` constant.
- **Sub-module `btn_sync_edge`:** parameter `SYNC_STAGES`; ports `clk`, `rst`, `btn`, `press`. Instantiated three times.
- The FSM and the prescaler live in the `stopwatch_ctrl` top level.

## Test plan
All scenarios run with `TICK_DIV=4` and `SYNC_STAGES=2`.
- **Start:** hold `start_btn` high from before edge 1 → `running` rises after edge 3. `count_en` pulses after edges 6, 10 and 14. `clear` stays 0.
- **Pause and resume:** stop press while `prescaler=2` → `running` falls and `count_en` stays 0 for 20 cycles. Start press → first `count_en` comes 1 cycle after `running` rises.
- **Simultaneous presses:** start, stop and reset pressed in the same cycle while RUNNING → state is IDLE, `clear`=1 for exactly 1 cycle, prescaler=0, no `count_en`.
- **Ignored presses:** stop press in IDLE → no change. Start press held for 50 cycles while RUNNING → no extra transition, and `count_en` spacing stays 4.
- **Mid-operation reset:** assert `rst` mid-cycle while RUNNING with `prescaler=3` → all outputs are 0 immediately, with no clock edge needed. With `start_btn` held through `rst` release → `running` rises 3 edges after release.
